// File: rtl/n2_idu_iq_ctrl.sv
// Instruction queue between fetch and decode/issue: in-order circular buffer with
// serial-instruction gating (wait for backend idle, hold younger until retire) and flush.
//
// state | meaning
// RUN   | normal issue; a serial head waits for be_idle_i before issuing
// HOLD  | a serial instruction has issued; nothing issues until serial_done_i
module n2_idu_iq_ctrl #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   fetch_valid_i,
  output logic                   fetch_ready_o,
  input  logic [31:0]            fetch_instr_i,
  input  logic [PC_W-1:0]        fetch_pc_i,
  input  logic                   fetch_serial_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [31:0]            issue_instr_o,
  output logic [PC_W-1:0]        issue_pc_o,
  output logic                   issue_serial_o,
  input  logic                   be_idle_i,
  input  logic                   serial_done_i,
  output logic                   serial_wait_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {RUN, HOLD} state_t;

  state_t          state, state_nxt;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [31:0]     instr_mem  [DEPTH];
  logic [PC_W-1:0] pc_mem     [DEPTH];
  logic            serial_mem [DEPTH];
  logic            empty, full, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Ready deliberately ignores issue_ready_i so there is no path across the queue.
  assign fetch_ready_o = !full && !flush_i;
  assign push          = fetch_valid_i && fetch_ready_o;
  assign pop           = issue_valid_o && issue_ready_i;
  assign count_o       = wr_ptr - rd_ptr;

  assign issue_instr_o  = instr_mem[rd_ptr[AW-1:0]];
  assign issue_pc_o     = pc_mem[rd_ptr[AW-1:0]];
  assign issue_serial_o = serial_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr[AW-1:0]]  <= fetch_instr_i;
      pc_mem[wr_ptr[AW-1:0]]     <= fetch_pc_i;
      serial_mem[wr_ptr[AW-1:0]] <= fetch_serial_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= RUN;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= RUN;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    issue_valid_o = 1'b0;
    serial_wait_o = 1'b0;
    case (state)
      RUN: begin
        if (!empty && !flush_i) begin
          if (issue_serial_o) begin
            issue_valid_o = be_idle_i;
            serial_wait_o = !be_idle_i;
          end else begin
            issue_valid_o = 1'b1;
          end
        end
        if (issue_valid_o && issue_ready_i && issue_serial_o) state_nxt = HOLD;
      end
      HOLD: begin
        if (serial_done_i) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: doc/n2_idu_iq_ctrl.md
# n2_idu_iq_ctrl

Instruction-queue controller between fetch and decode/issue in the N2 IDU. It buffers fetched instructions, already tagged by predecode, in a small circular queue and issues them in program order through a valid/ready handshake. It serializes "serial" instructions (trap, ecall/ebreak, counter reads, retirq, maskirq): such an instruction waits for the backend to drain, and nothing younger issues until it completes. It also discards all queued instructions on a redirect flush.

## Interface
- DEPTH, 4: queue entries; power of 2, at least 2.
- PC_W, 32: PC width.
- clk_i  in  1  clock; everything is on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  redirect; empties the queue and returns the FSM to RUN.
- fetch_valid_i  in  1  fetch offers an entry.
- fetch_ready_o  out  1  queue accepts the offered entry.
- fetch_instr_i  in  32  raw instruction word.
- fetch_pc_i  in  PC_W  instruction PC.
- fetch_serial_i  in  1  predecode serial tag.
- issue_valid_o  out  1  head entry is issuable.
- issue_ready_i  in  1  decode/issue accepts the head.
- issue_instr_o  out  32  head instruction.
- issue_pc_o  out  PC_W  head PC.
- issue_serial_o  out  1  head serial tag.
- be_idle_i  in  1  backend has no instruction in flight.
- serial_done_i  in  1  one-cycle pulse: the issued serial instruction retired.
- serial_wait_o  out  1  head is serial and blocked on be_idle_i.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage: DEPTH entries, each holding {instr, pc, serial}.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide, with the MSB used as a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
- Push:
  - fetch_ready_o = !full && !flush_i. There is no combinational path from issue_ready_i, so a full queue refuses a push even in a cycle that pops.
  - A push happens when fetch_valid_i && fetch_ready_o. It writes mem[wr_ptr] and increments wr_ptr, wrapping modulo 2*DEPTH.
- Head: issue_instr_o, issue_pc_o and issue_serial_o read mem[rd_ptr]. They are don't-care when the queue is empty.
- FSM states: RUN, HOLD.
  - RUN, head not serial: issue_valid_o = !empty && !flush_i.
  - RUN, head serial: issue_valid_o = !empty && !flush_i && be_idle_i; serial_wait_o = !empty && !flush_i && !be_idle_i.
  - RUN -> HOLD on a serial head handshake.
  - HOLD: issue_valid_o = 0. serial_done_i moves the FSM to RUN.
  - serial_done_i is ignored in RUN.
- Pop: happens when issue_valid_o && issue_ready_i, and increments rd_ptr.
- count_o = wr_ptr - rd_ptr, computed modulo 2*DEPTH.
- Flush:
  - Next edge: wr_ptr = rd_ptr = 0 and state = RUN.
  - In the flush cycle itself, fetch_ready_o = 0 and issue_valid_o = 0, so no push or pop occurs.
  - A flush in HOLD abandons the pending serial_done_i. A serial_done_i arriving afterwards is ignored.
- Simultaneous push and pop, not full: both happen and count_o is unchanged.

## Timing
- Reset values (asserted asynchronously):
  - Pointers 0, state RUN, count_o = 0.
  - issue_valid_o = 0, serial_wait_o = 0.
  - fetch_ready_o = 1, because the queue is empty and flush_i is low.
  - Memory contents are not reset.
- Reset applied mid-operation discards all entries and any HOLD immediately.
- Latency:
  - A push at edge N makes issue_valid_o = 1 in cycle N+1 (no empty bypass).
  - Sustained throughput is 1 entry/cycle in each direction.
- Serial path:
  - Issue occurs in the first cycle the serial entry is at the head with be_idle_i = 1.
  - The next entry can issue no earlier than the cycle after serial_done_i.
- Handshake: while the queue is not flushed, issue_valid_o is not withdrawn without a pop, except that it drops when be_idle_i falls while a serial entry is at the head.
- issue_valid_o, fetch_ready_o and serial_wait_o are combinational from state and flops, plus flush_i and be_idle_i. They have no dependence on the other side's valid/ready.

## Test plan
- Fill/drain, DEPTH=4:
  - Push 0x00000013@pc 0x100, 0x00100093@0x104, 0x00200113@0x108, 0x00300193@0x10C with issue_ready_i = 0 -> count_o = 4, fetch_ready_o = 0.
  - Raise issue_ready_i -> the four entries issue in order over 4 cycles and count_o returns to 0.
- Wrap: run 10 push+pop cycles back-to-back with PCs 0x200..0x224 -> issued PCs match in order, count_o stays at 1, and no entry is dropped or duplicated across the pointer wrap.
- Serial drain:
  - Queue a non-serial entry A and serial ecall 0x00000073 (fetch_serial_i = 1), with be_idle_i = 0 after A issues.
  - -> ecall held with serial_wait_o = 1.
  - be_idle_i = 1 -> ecall issues that cycle and the FSM enters HOLD.
  - A younger entry C is queued and is not issued until the cycle after serial_done_i.
- Flush in HOLD:
  - With 2 entries queued and state HOLD, pulse flush_i with fetch_valid_i = 1 -> no push that cycle.
  - Next cycle: count_o = 0, state RUN. A later serial_done_i has no effect.
- Reset mid-stream: assert rst_ni low asynchronously with 3 entries queued -> count_o = 0 and issue_valid_o = 0 immediately, fetch_ready_o = 1.
- Full with pop:
  - With count_o = 4 and issue_ready_i = 1, hold fetch_valid_i = 1 -> that cycle: pop only, fetch_ready_o = 0.
  - Next cycle: fetch_ready_o = 1, and push plus pop both occur.
